// File: rtl/module_rca_sequencer.sv
// Word-serial wide adder: a single RCAWIDE-bit ripple carry adder is reused
// once per word, least-significant word first, with the carry kept in a
// register between words. The wide result is published in one step when the
// last word has been added, so no partial sum is ever visible on sum_o.
`timescale 1ns/1ps

// Combinational ripple carry adder of configurable width.
module module_ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Bit-by-bit full-adder chain, carry rippling from bit 0 upwards.
  always_comb begin
    // NOTE: blocking '=' is correct here: 'carry' is a temporary that must
    // carry the value from the previous loop iteration within this block.
    logic carry;
    carry = carry_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
    end
    carry_o = carry;
  end

endmodule

// Sequencer that walks the operand words through the shared adder.
module module_rca_sequencer #(
  parameter int RCAWIDE = 8,
  parameter int NWORDS  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [RCAWIDE*NWORDS-1:0]  a_i,
  input  logic [RCAWIDE*NWORDS-1:0]  b_i,
  input  logic                       carry_i,
  output logic                       ready_o,
  output logic                       done_o,
  output logic [RCAWIDE*NWORDS-1:0]  sum_o,
  output logic                       carry_o
);

  localparam int W    = RCAWIDE * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q,     a_d;
  logic [W-1:0]      b_q,     b_d;
  logic [W-1:0]      res_q,   res_d;
  logic [W-1:0]      sum_q,   sum_d;
  logic              cout_q,  cout_d;

  logic [RCAWIDE-1:0] add_a;
  logic [RCAWIDE-1:0] add_b;
  logic [RCAWIDE-1:0] add_sum;
  logic               add_cout;

  // Current word of each captured operand feeds the shared adder.
  assign add_a = a_q[idx_q*RCAWIDE +: RCAWIDE];
  assign add_b = b_q[idx_q*RCAWIDE +: RCAWIDE];

  module_ripple_carry_adder #(
    .WIDTH (RCAWIDE)
  ) u_rca (
    .a_i     (add_a),
    .b_i     (add_b),
    .carry_i (carry_q),
    .sum_o   (add_sum),
    .carry_o (add_cout)
  );

  // Next-state and datapath update: capture in IDLE, one word per ADD cycle,
  // publish the full result on the ADD->DONE transition.
  always_comb begin
    // NOTE: every signal gets a hold default first so no branch leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = carry_i;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        res_d[idx_q*RCAWIDE +: RCAWIDE] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // idx is left at its last value so it never wraps inside ADD.
          sum_d   = res_d;
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the wide operand/result registers are reset too, so an aborted
    // operation leaves no stale data behind and outputs are 0 out of reset.
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign carry_o = cout_q;

endmodule

// File: tb/tb_module_rca_sequencer.sv
// Directed and random checks of module_rca_sequencer against the plain
// arithmetic reference {carry, sum} = A + B + cin.
`timescale 1ns/1ps

module tb_module_rca_sequencer;

  localparam int RCAWIDE = 8;
  localparam int NWORDS  = 4;
  localparam int W       = RCAWIDE * NWORDS;
  localparam int PERIOD  = NWORDS + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int done_pulses = 0;

  module_rca_sequencer #(
    .RCAWIDE (RCAWIDE),
    .NWORDS  (NWORDS)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .carry_i (cin),
    .ready_o (ready),
    .done_o  (done),
    .sum_o   (sum),
    .carry_o (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (done === 1'b1) done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  // One operation: present operands with start, wait (bounded) for ready, let
  // the edge accept it, scramble the inputs, then wait (bounded) for done.
  // lat counts cycles from the acceptance cycle to the done cycle.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_c, input bit hold_start,
                        output int lat, output logic [W:0] res, output int done_cycle);
    bit got;
    a = op_a; b = op_b; cin = op_c; start = 1'b1;
    lat = -1; res = 'x; done_cycle = -1;
    got = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    a = ~op_a; b = ~op_b; cin = ~op_c;
    for (int n = 1; n <= 3 * PERIOD; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n; res = {cout, sum}; done_cycle = cycle;
        check("ready_in_done", 64'(ready), 64'd0);
        break;
      end
      check("ready_in_add", 64'(ready), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  int           lat;
  int           dc;
  int           dcs [3];
  int           snap;
  logic [W:0]   res;
  logic [W:0]   exp_v;
  logic [W-1:0] ra, rb;
  logic         rc;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state, asserted before any clock edge.
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done",  64'(done),  64'd0);
    check("rst_sum",   64'(sum),   64'd0);
    check("rst_cout",  64'(cout),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry chain through every word.
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, res, dc);
    check("full_chain_res", 64'(res), 64'(golden(32'hFFFF_FFFF, 32'h0, 1'b1)));
    check("full_chain_cout", 64'(res[W]), 64'd1);
    check("full_chain_lat", 64'(lat), 64'(NWORDS + 1));
    check("hold_after_done", 64'({cout, sum}), 64'h1_0000_0000);

    // Carry across a word boundary.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, res, dc);
    check("inter_word_res", 64'(res), 64'h0_0000_0100);

    // Busy rejection: start pulse with new operands during ADD is ignored.
    snap = done_pulses;
    a = 32'd1; b = 32'd1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    check("busy_ready_before", 64'(ready), 64'd1);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    check("busy_ready_add", 64'(ready), 64'd0);
    @(posedge clk); #1; start = 1'b0;
    repeat (2 * PERIOD) @(posedge clk);
    #1;
    check("busy_single_done", 64'(done_pulses), 64'(snap + 1));
    check("busy_sum", 64'(sum), 64'd2);
    check("busy_cout", 64'(cout), 64'd0);

    // Reset in the middle of ADD (idx = 2), then a fresh 3 + 4.
    a = 32'h1234_5678; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_done",  64'(done),  64'd0);
    check("midrst_sum",   64'(sum),   64'd0);
    check("midrst_cout",  64'(cout),  64'd0);
    snap = done_pulses;
    a = 32'd3; b = 32'd4; cin = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    check("accept_first_edge", 64'(ready), 64'd0);
    lat = -1;
    for (int n = 1; n <= 3 * PERIOD; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = n; break; end
    end
    check("post_rst_lat", 64'(lat), 64'(NWORDS + 1));
    check("post_rst_sum", 64'(sum), 64'd7);
    check("no_done_from_abort", 64'(done_pulses), 64'(snap));
    @(posedge clk); #1;

    // Back-to-back with start held high.
    for (int k = 0; k < 3; k++) begin
      ra = rand_word(); rb = rand_word(); rc = 1'($urandom);
      exp_v = golden(ra, rb, rc);
      run_op(ra, rb, rc, 1'b1, lat, res, dcs[k]);
      check($sformatf("b2b_res%0d", k), 64'(res), 64'(exp_v));
    end
    start = 1'b0;
    check("b2b_gap01", 64'(dcs[1] - dcs[0]), 64'(PERIOD));
    check("b2b_gap12", 64'(dcs[2] - dcs[1]), 64'(PERIOD));

    // Random operands against the arithmetic model; stop at first mismatch.
    for (int k = 0; k < 50; k++) begin
      ra = rand_word(); rb = rand_word(); rc = 1'($urandom);
      exp_v = golden(ra, rb, rc);
      snap = n_fail;
      run_op(ra, rb, rc, 1'b0, lat, res, dc);
      check($sformatf("rand%0d", k), 64'(res), 64'(exp_v));
      if (n_fail != snap) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "FAIL random stop at op %0d a=0x%0h b=0x%0h cin=%0d", k, ra, rb, rc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
